pxs_game_render: RTL and testbench

- Read side of the Pxs game table. The game-update block writes 4-bit tile codes into the table; this block reads them.
- Walks the 26-bit pixel stream, fetches the tile code under each pixel through a synchronous read port, and overlays procedurally drawn sprites (pacman open/closed, ghost) onto the stream RGB.
- Sits between the video timing/stream generator and the VGA output stage, on the read port of the dual-port game-table RAM.

---
 rtl/pxs_game_render_if.sv | 30 +++
 rtl/pxs_game_render.sv | 133 +++++++++++++
 tb/tb_pxs_game_render.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pxs_game_render_if.sv
// ============================================================================
// pxs_game_render_if : pixel stream in/out and game-table read port bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface pxs_game_render_if;
    logic [25:0] RGBStr_i;
    logic [10:0] TabAdd_rd;
    logic [3:0]  TabDat_rd;
    logic [25:0] RGBStr_o;

    // Renderer side: consumes the stream and table data, drives address and output
    modport slave (
        input  RGBStr_i,
        input  TabDat_rd,
        output TabAdd_rd,
        output RGBStr_o
    );

    // Environment side: stream source, table RAM and output sink
    modport master (
        output RGBStr_i,
        output TabDat_rd,
        input  TabAdd_rd,
        input  RGBStr_o
    );
endinterface

`default_nettype wire

// File: rtl/pxs_game_render.sv
// ============================================================================
// pxs_game_render : game-table lookup and sprite overlay on the pixel stream
// Optional macro PXS_RENDER_GRID_EN draws blue grid lines on empty tiles.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pxs_game_render #(
    parameter int VISIBLECOLS = 640,
    parameter int VISIBLEROWS = 480,
    parameter int TAB_COLS    = 40,
    parameter int BLINK_LOG2  = 4
) (
    input  wire logic          px_clk,
    input  wire logic          rst_n,
    pxs_game_render_if.slave   bus
);
    localparam logic [9:0] C_COLS = 10'(VISIBLECOLS);
    localparam logic [9:0] C_ROWS = 10'(VISIBLEROWS);

    localparam logic [1:0] CODE_NONE   = 2'd0;
    localparam logic [1:0] CODE_GHOST  = 2'd1;
    localparam logic [1:0] CODE_PAC_CL = 2'd2;
    localparam logic [1:0] CODE_PAC_OP = 2'd3;

    logic [9:0]  xc, yc;
    logic [10:0] tab_add_d, tab_add_q;
    logic        off_d, endframe;
    logic [25:0] s1_str_q, s2_str_q, rgb_str_d, rgb_str_q;
    logic [3:0]  s1_x_q, s1_y_q, s2_x_q, s2_y_q;
    logic        s1_off_q, s2_off_q;
    logic [BLINK_LOG2-1:0] frame_cnt_d, frame_cnt_q;
    logic        blink_d, blink_q;

    assign xc = bus.RGBStr_i[22:13];
    assign yc = bus.RGBStr_i[12:3];

    // Stage 0: row*40 as row*32 + row*8, then add the tile column
    always_comb begin
        off_d     = (xc >= C_COLS) || (yc >= C_ROWS);
        tab_add_d = {yc[9:4], 5'b0} + {2'b0, yc[9:4], 3'b0} + {5'b0, xc[9:4]};
        if (off_d) begin
            tab_add_d = 11'd0;
        end
        endframe    = (xc == C_COLS - 10'd1) && (yc == C_ROWS - 10'd1);
        frame_cnt_d = endframe ? frame_cnt_q + 1'b1 : frame_cnt_q;
        blink_d     = blink_q ^ (endframe && (&frame_cnt_q));
    end

    // Stage 2: sprite geometry in half-pixel units around the tile centre
    logic signed [5:0] dx, dy;
    logic [5:0]  adx, ady;
    logic [9:0]  d2;
    logic [1:0]  code;
    logic        active, ghost_body, eye, pac_body, mouth;
    logic [2:0]  rgb;

    always_comb begin
        dx     = $signed({1'b0, s2_x_q, 1'b1}) - 6'sd15;
        dy     = $signed({1'b0, s2_y_q, 1'b1}) - 6'sd15;
        adx    = dx[5] ? 6'(-dx) : 6'(dx);
        ady    = dy[5] ? 6'(-dy) : 6'(dy);
        d2     = ({4'd0, adx} * {4'd0, adx}) + ({4'd0, ady} * {4'd0, ady});
        active = s2_str_q[0];
        code   = (s2_off_q || !active || (bus.TabDat_rd > 4'd3)) ? CODE_NONE
                                                                  : bus.TabDat_rd[1:0];
        ghost_body = (!dy[5] && (adx <= 6'd13)) || (d2 <= 10'd169);
        eye        = ((s2_x_q == 4'd4) || (s2_x_q == 4'd5) || (s2_x_q == 4'd10) ||
                      (s2_x_q == 4'd11)) && ((s2_y_q == 4'd5) || (s2_y_q == 4'd6));
        pac_body   = (d2 <= 10'd196);
        mouth      = dx[5] && (ady < adx);

        rgb = s2_str_q[25:23];
        case (code)
            CODE_GHOST: begin
                if (ghost_body) begin
                    rgb = eye ? 3'b111 : (blink_q ? 3'b101 : 3'b100);
                end
            end
            CODE_PAC_CL: begin
                if (pac_body) rgb = 3'b110;
            end
            CODE_PAC_OP: begin
                if (pac_body && !mouth) rgb = 3'b110;
            end
            default: begin
`ifdef PXS_RENDER_GRID_EN
                if (active && ((s2_x_q == 4'd0) || (s2_y_q == 4'd0))) rgb = 3'b001;
`endif
            end
        endcase
        if (!active) begin
            rgb = 3'b000;
        end
        rgb_str_d = {rgb, s2_str_q[22:0]};
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            tab_add_q   <= 11'd0;
            s1_str_q    <= 26'd0;
            s1_x_q      <= 4'd0;
            s1_y_q      <= 4'd0;
            s1_off_q    <= 1'b0;
            s2_str_q    <= 26'd0;
            s2_x_q      <= 4'd0;
            s2_y_q      <= 4'd0;
            s2_off_q    <= 1'b0;
            rgb_str_q   <= 26'd0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            tab_add_q   <= tab_add_d;
            s1_str_q    <= bus.RGBStr_i;
            s1_x_q      <= xc[3:0];
            s1_y_q      <= yc[3:0];
            s1_off_q    <= off_d;
            s2_str_q    <= s1_str_q;
            s2_x_q      <= s1_x_q;
            s2_y_q      <= s1_y_q;
            s2_off_q    <= s1_off_q;
            rgb_str_q   <= rgb_str_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign bus.TabAdd_rd = tab_add_q;
    assign bus.RGBStr_o  = rgb_str_q;

endmodule

`default_nettype wire

// File: tb/tb_pxs_game_render.sv
// ============================================================================
// tb_pxs_game_render : randomized bench with a behavioural render model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pxs_game_render;
    logic px_clk = 1'b0;
    logic rst_n  = 1'b0;
    pxs_game_render_if bus();

    pxs_game_render dut (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 px_clk = ~px_clk;

    logic [3:0] tbl [0:2047];
    always @(posedge px_clk) bus.TabDat_rd <= tbl[bus.TabAdd_rd];

    int n_cmp = 0;
    int n_err = 0;
    int ef_count = 0;
    logic [25:0] pq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] mk(input int xc, input int yc, input bit act,
                                       input bit hs, input bit vs, input logic [2:0] rgb);
        logic [9:0] x10 = 10'(xc);
        logic [9:0] y10 = 10'(yc);
        return {rgb, x10, y10, hs, vs, act};
    endfunction

    function automatic int ref_addr(input logic [25:0] s);
        int xc = int'(s[22:13]);
        int yc = int'(s[12:3]);
        if (xc >= 640 || yc >= 480) return 0;
        return (yc / 16) * 40 + xc / 16;
    endfunction

    function automatic logic [2:0] ref_rgb(input logic [25:0] s, input bit blink);
        int xc = int'(s[22:13]);
        int yc = int'(s[12:3]);
        int x = xc % 16;
        int y = yc % 16;
        int dx = 2 * x + 1 - 15;
        int dy = 2 * y + 1 - 15;
        int d2 = dx * dx + dy * dy;
        int adx = (dx < 0) ? -dx : dx;
        int ady = (dy < 0) ? -dy : dy;
        int code = 0;
        logic [2:0] rgb = s[25:23];
        if (!s[0]) return 3'b000;
        if (xc < 640 && yc < 480) code = int'(tbl[ref_addr(s)]);
        if (code == 1) begin
            if ((dy >= 0 && adx <= 13) || d2 <= 169) begin
                if ((x == 4 || x == 5 || x == 10 || x == 11) && (y == 5 || y == 6))
                    rgb = 3'b111;
                else
                    rgb = blink ? 3'b101 : 3'b100;
            end
        end else if (code == 2) begin
            if (d2 <= 196) rgb = 3'b110;
        end else if (code == 3) begin
            if (d2 <= 196 && !(dx < 0 && ady < adx)) rgb = 3'b110;
        end else begin
`ifdef PXS_RENDER_GRID_EN
            if (x == 0 || y == 0) rgb = 3'b001;
`endif
        end
        return rgb;
    endfunction

    // Output after edge m belongs to the pixel sampled at edge m-2 and sees the
    // blink state reached before edge m.
    task automatic step(input logic [25:0] s, input string tag);
        bit blink_before = ((ef_count / 16) % 2) == 1;
        logic [25:0] old;
        bus.RGBStr_i = s;
        @(posedge px_clk);
        pq.push_back(s);
        if (s[22:13] == 10'd639 && s[12:3] == 10'd479) ef_count++;
        #1;
        chk({tag, "_addr"}, 32'(bus.TabAdd_rd), 32'(ref_addr(s)));
        if (pq.size() == 3) begin
            old = pq.pop_front();
            chk({tag, "_out"}, 32'(bus.RGBStr_o), 32'({ref_rgb(old, blink_before), old[22:0]}));
        end else begin
            chk({tag, "_out_rst"}, 32'(bus.RGBStr_o), 32'd0);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(mk(700, 10, 1'b0, i[0], ~i[0], 3'b111), "blank");
    endtask

    task automatic rand_run(input int n);
        int xc, yc;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(49) == 0) begin
                xc = 639; yc = 479;
            end else begin
                xc = int'($urandom_range(799));
                yc = int'($urandom_range(524));
            end
            step(mk(xc, yc, (xc < 640 && yc < 480) ? ($urandom_range(7) != 0) : 1'b0,
                    1'($urandom), 1'($urandom), 3'($urandom)), "rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) tbl[i] = 4'($urandom);
        bus.RGBStr_i = '0;
        repeat (2) @(posedge px_clk);
        #1;
        chk("reset_out", 32'(bus.RGBStr_o), 32'd0);
        chk("reset_addr", 32'(bus.TabAdd_rd), 32'd0);
        rst_n = 1'b1;

        tbl[126] = 4'd3;
        step(mk(100, 50, 1'b1, 1'b0, 1'b0, 3'b010), "addr126");
        step(mk(103, 55, 1'b1, 1'b0, 1'b0, 3'b010), "pac_open_body");
        step(mk(97, 55, 1'b1, 1'b0, 1'b0, 3'b010), "pac_open_mouth");
        flush();
        tbl[126] = 4'd2;
        step(mk(97, 55, 1'b1, 1'b0, 1'b0, 3'b010), "pac_closed");
        step(mk(96, 53, 1'b1, 1'b0, 1'b0, 3'b000), "grid_px");
        tbl[200] = 4'd1;
        tbl[199] = 4'd0;
        flush();
        step(mk(4, 85, 1'b1, 1'b0, 1'b0, 3'b000), "ghost_eye");
        step(mk(7, 95, 1'b1, 1'b0, 1'b0, 3'b000), "ghost_body");
        step(mk(700, 10, 1'b0, 1'b1, 1'b0, 3'b111), "blank_hs");
        step(mk(700, 10, 1'b0, 1'b0, 1'b1, 3'b111), "blank_vs");
        for (int i = 0; i < 16; i++) step(mk(639, 479, 1'b0, 1'b0, 1'b0, 3'b011), "endframe");
        flush();
        step(mk(7, 95, 1'b1, 1'b0, 1'b0, 3'b000), "ghost_blink");
        step(mk(4, 85, 1'b1, 1'b0, 1'b0, 3'b000), "ghost_eye_blink");

        rand_run(1500);

        // Asynchronous reset in the middle of a line
        step(mk(320, 200, 1'b1, 1'b0, 1'b0, 3'b101), "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", 32'(bus.RGBStr_o), 32'd0);
        chk("midrst_addr", 32'(bus.TabAdd_rd), 32'd0);
        pq.delete();
        ef_count = 0;
        @(negedge px_clk);
        rst_n = 1'b1;
        step(mk(7, 95, 1'b1, 1'b0, 1'b0, 3'b000), "post_rst");
        step(mk(8, 95, 1'b1, 1'b0, 1'b0, 3'b000), "post_rst");
        step(mk(9, 95, 1'b1, 1'b0, 1'b0, 3'b000), "post_rst_ghost");

        rand_run(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
